// File: rtl/game_pkg.sv
// -----------------------------------------------------------------------------
// game_pkg
// Definitions shared by the game state FSM and the round timer.
//   GAME_ON / HIGHSCORE : encoding of the FSM's game_state output
//   timer_state_t       : round timer states (IDLE, RUN, EXPIRED)
//   bcd_digit_t         : one BCD digit
//   to_bcd2()           : binary 0..99 -> {tens, ones} BCD byte
//   bcd2_value()        : {tens, ones} BCD -> binary value
// -----------------------------------------------------------------------------
package game_pkg;

    localparam logic GAME_ON   = 1'b0;
    localparam logic HIGHSCORE = 1'b1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } timer_state_t;

    typedef logic [3:0] bcd_digit_t;

    function automatic logic [7:0] to_bcd2(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic int bcd2_value(input bcd_digit_t t, input bcd_digit_t o);
        return int'(t) * 10 + int'(o);
    endfunction

endpackage

// File: rtl/bcd_down2.sv
// -----------------------------------------------------------------------------
// bcd_down2
// Two-digit BCD down-counter. Load has priority over decrement; a decrement
// applied at 00 is ignored so the value never wraps.
//   clk, rst   : clock, asynchronous active-high reset (value -> 00)
//   load       : load load_val ({tens, ones}) on the next edge
//   load_val   : BCD value to load
//   dec        : decrement by one on the next edge
//   tens, ones : current BCD digits
//   zero       : high while the value is 00
// -----------------------------------------------------------------------------
module bcd_down2
    import game_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       dec,
    output bcd_digit_t tens,
    output bcd_digit_t ones,
    output logic       zero
);

    assign zero = (tens == 4'd0) && (ones == 4'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tens <= 4'd0;
            ones <= 4'd0;
        end else if (load) begin
            tens <= load_val[7:4];
            ones <= load_val[3:0];
        end else if (dec && !zero) begin
            // Borrow from the tens digit when the ones digit is exhausted.
            if (ones == 4'd0) begin
                ones <= 4'd9;
                tens <= tens - 4'd1;
            end else begin
                ones <= ones - 4'd1;
            end
        end
    end

endmodule

// File: rtl/game_timer.sv
// -----------------------------------------------------------------------------
// game_timer
// Round countdown timer feeding the game state FSM. A HIGHSCORE->GAME_ON
// transition of game_state (re)loads GAME_SECS and counts down once every
// CLK_HZ cycles; reaching 00 emits a one-cycle time_up pulse. Returning to
// HIGHSCORE mid-round aborts the round and freezes the displayed seconds.
//
// Optional feature macro: GAME_TIMER_WARN_EN
//   When defined, adds output `warn`, which blinks at 1 Hz while running with
//   the remaining seconds <= WARN_SECS (forced high whenever the seconds step).
//
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   game_state : FSM state (GAME_ON = 0, HIGHSCORE = 1)
//   time_up    : one-cycle pulse when the countdown reaches 00
//   running    : high while counting
//   secs_tens  : BCD tens digit of remaining seconds
//   secs_ones  : BCD ones digit of remaining seconds
//   warn       : (GAME_TIMER_WARN_EN only) low-time warning blink
// -----------------------------------------------------------------------------
module game_timer
    import game_pkg::*;
#(
    parameter int CLK_HZ    = 50_000_000,
    parameter int GAME_SECS = 30,
    parameter int WARN_SECS = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       game_state,
    output logic       time_up,
    output logic       running,
    output bcd_digit_t secs_tens,
    output bcd_digit_t secs_ones
`ifdef GAME_TIMER_WARN_EN
    ,
    output logic       warn
`endif
);

    // Elaboration-time parameter checks.
    if (CLK_HZ < 2) begin : g_bad_clk_hz
        $error("game_timer: CLK_HZ must be >= 2");
    end
    if (GAME_SECS < 1 || GAME_SECS > 99) begin : g_bad_game_secs
        $error("game_timer: GAME_SECS must be in 1..99");
    end
    if (WARN_SECS >= GAME_SECS) begin : g_bad_warn_secs
        $error("game_timer: WARN_SECS must be < GAME_SECS");
    end

    localparam int            PW         = $clog2(CLK_HZ);
    localparam logic [PW-1:0] PRESC_MAX  = PW'(CLK_HZ - 1);
    localparam logic [7:0]    START_BCD  = to_bcd2(GAME_SECS);

    timer_state_t  state, state_d;
    logic          game_state_q;
    logic [PW-1:0] presc;
    logic          start, tick, expiry, abort_run, dec, cnt_zero;

    // Start is the GAME_ON entry edge; game_state_q resets to HIGHSCORE so a
    // game_state already at GAME_ON when reset releases also counts as a start.
    assign start     = (game_state == GAME_ON) && (game_state_q == HIGHSCORE);
    assign tick      = (state == RUN) && (presc == PRESC_MAX);
    assign expiry    = tick && (secs_tens == 4'd0) && (secs_ones == 4'd1);
    // Expiry wins over an abort requested in the same cycle.
    assign abort_run = (state == RUN) && (game_state == HIGHSCORE) && !expiry;
    // Start wins over a tick; an abort freezes the displayed value.
    assign dec       = tick && !start && !abort_run && !cnt_zero;
    assign running   = (state == RUN);

    always_comb begin
        state_d = state;
        if (start) begin
            state_d = RUN;
        end else begin
            case (state)
                RUN: begin
                    if (expiry)         state_d = EXPIRED;
                    else if (abort_run) state_d = IDLE;
                end
                EXPIRED: begin
                    if (game_state == HIGHSCORE) state_d = IDLE;
                end
                default: state_d = state;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            game_state_q <= HIGHSCORE;
            time_up      <= 1'b0;
            presc        <= '0;
        end else begin
            state        <= state_d;
            game_state_q <= game_state;
            time_up      <= expiry && !start;
            if (start || state != RUN || tick) presc <= '0;
            else                               presc <= presc + 1'b1;
        end
    end

    bcd_down2 u_secs (
        .clk      (clk),
        .rst      (rst),
        .load     (start),
        .load_val (START_BCD),
        .dec      (dec),
        .tens     (secs_tens),
        .ones     (secs_ones),
        .zero     (cnt_zero)
    );

`ifdef GAME_TIMER_WARN_EN
    localparam logic [PW-1:0] PRESC_HALF = PW'(CLK_HZ / 2 - 1);

    int   cur_val;
    logic warn_d;

    assign cur_val = bcd2_value(secs_tens, secs_ones);

    // The blink phase restarts high at each seconds step, then toggles at the
    // half-second point of the prescaler.
    always_comb begin
        warn_d = warn;
        if (start || state_d != RUN)        warn_d = 1'b0;
        else if (dec)                       warn_d = (cur_val - 1) <= WARN_SECS;
        else if (cur_val > WARN_SECS)       warn_d = 1'b0;
        else if (presc == PRESC_HALF)       warn_d = ~warn;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) warn <= 1'b0;
        else     warn <= warn_d;
    end
`endif

endmodule
